mem_copy_master: RTL and testbench

// - Bus initiator for the req/gnt/rvalid memory port served by sp_ram.
// - Copies a block of LEN words from a source byte address to a destination byte address.
// - Each word is read, then written back.
// - Sits between a control source (core, CSR or bench) and any sp_ram-style responder.

---
 rtl/mem_copy_master.sv | 112 +++++++++++
 tb/tb_mem_copy_master.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_copy_master.sv
// mem_copy_master: req/gnt/rvalid bus initiator copying LEN words from src to dst.
// Define MEM_COPY_VERIFY_EN to read back each written word and flag mismatches on err_o.
module mem_copy_master #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start_i,
    input  logic [ADDR_WIDTH-1:0]   src_addr_i,
    input  logic [ADDR_WIDTH-1:0]   dst_addr_i,
    input  logic [LEN_WIDTH-1:0]    len_i,
    output logic                    busy_o,
    output logic                    done_o,
    output logic                    err_o,
    output logic                    req_o,
    output logic [ADDR_WIDTH-1:0]   addr_o,
    output logic                    we_o,
    output logic [DATA_WIDTH-1:0]   wdata_o,
    output logic [DATA_WIDTH/8-1:0] be_o,
    input  logic                    gnt_i,
    input  logic                    rvalid_i,
    input  logic [DATA_WIDTH-1:0]   rdata_i
);
    localparam int BPW = DATA_WIDTH / 8;

    typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, VF_REQ, VF_WAIT} state_t;

    state_t                  r_state, w_next;
    logic [ADDR_WIDTH-1:0]   r_src, r_dst;
    logic [LEN_WIDTH-1:0]    r_cnt;
    logic [DATA_WIDTH-1:0]   r_data;
    logic                    r_done;
    logic                    w_start, w_start_zero, w_word_done, w_last;
    state_t                  w_after_word, w_after_wr;

    assign w_start      = (r_state == IDLE) && start_i;
    assign w_start_zero = w_start && (len_i == '0);
    assign w_last       = (r_cnt == LEN_WIDTH'(1));
    assign w_after_word = w_last ? IDLE : RD_REQ;

`ifdef MEM_COPY_VERIFY_EN
    logic r_err;
    assign w_word_done = (r_state == VF_WAIT) && rvalid_i;
    assign w_after_wr  = VF_REQ;
    assign err_o       = r_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_err <= 1'b0;
        else if (w_start)
            r_err <= 1'b0;
        else if (w_word_done && rdata_i != r_data)
            r_err <= 1'b1;
    end
`else
    assign w_word_done = (r_state == WR_WAIT) && rvalid_i;
    assign w_after_wr  = w_after_word;
    assign err_o       = 1'b0;
`endif

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = (start_i && len_i != '0) ? RD_REQ : IDLE;
            RD_REQ:  w_next = gnt_i ? RD_WAIT : RD_REQ;
            RD_WAIT: w_next = rvalid_i ? WR_REQ : RD_WAIT;
            WR_REQ:  w_next = gnt_i ? WR_WAIT : WR_REQ;
            WR_WAIT: w_next = rvalid_i ? w_after_wr : WR_WAIT;
            VF_REQ:  w_next = gnt_i ? VF_WAIT : VF_REQ;
            VF_WAIT: w_next = rvalid_i ? w_after_word : VF_WAIT;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_src   <= '0;
            r_dst   <= '0;
            r_cnt   <= '0;
            r_data  <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_done  <= w_start_zero || (w_word_done && w_last);
            if (w_start) begin
                r_src <= src_addr_i;
                r_dst <= dst_addr_i;
                r_cnt <= len_i;
            end
            if (r_state == RD_WAIT && rvalid_i)
                r_data <= rdata_i;
            // Address wrap modulo 2^ADDR_WIDTH falls out of the truncating add
            if (w_word_done) begin
                r_src <= r_src + ADDR_WIDTH'(BPW);
                r_dst <= r_dst + ADDR_WIDTH'(BPW);
                r_cnt <= r_cnt - LEN_WIDTH'(1);
            end
        end
    end

    assign busy_o  = (r_state != IDLE);
    assign done_o  = r_done;
    assign req_o   = (r_state == RD_REQ) || (r_state == WR_REQ) || (r_state == VF_REQ);
    assign we_o    = (r_state == WR_REQ);
    assign addr_o  = (r_state == RD_REQ) ? r_src :
                     (r_state == WR_REQ || r_state == VF_REQ) ? r_dst : '0;
    assign wdata_o = (r_state == WR_REQ) ? r_data : '0;
    assign be_o    = '1;
endmodule

// File: tb/tb_mem_copy_master.sv
// tb_mem_copy_master: directed tests of mem_copy_master against a word memory responder.
// Define MEM_COPY_VERIFY_EN to exercise the readback/err_o path.
module tb_mem_copy_master;
`ifdef MEM_COPY_VERIFY_EN
    localparam int TPW = 3;
`else
    localparam int TPW = 2;
`endif

    logic        clk = 1'b0, rst_n = 1'b0, start_i = 1'b0;
    logic [7:0]  src_addr_i = '0, dst_addr_i = '0, len_i = '0;
    logic        busy_o, done_o, err_o, req_o, we_o, gnt_i, rvalid_i;
    logic [7:0]  addr_o;
    logic [31:0] wdata_o, rdata_i;
    logic [3:0]  be_o;

    mem_copy_master dut (
        .clk(clk), .rst_n(rst_n), .start_i(start_i), .src_addr_i(src_addr_i),
        .dst_addr_i(dst_addr_i), .len_i(len_i), .busy_o(busy_o), .done_o(done_o),
        .err_o(err_o), .req_o(req_o), .addr_o(addr_o), .we_o(we_o), .wdata_o(wdata_o),
        .be_o(be_o), .gnt_i(gnt_i), .rvalid_i(rvalid_i), .rdata_i(rdata_i)
    );

    always #5 clk = ~clk;

    int n_checks = 0, n_fail = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    logic [31:0] mem [64];
    logic [7:0]  log_addr [256];
    logic        log_we [256];
    int          log_n = 0, hold = 0, gcnt = 0, stab_err = 0;
    logic [7:0]  bad_addr = 8'hFF;
    logic        rv = 1'b0, pl_en = 1'b0;
    logic [31:0] rd = '0, pl_data = '0, h_wdata = '0;
    logic [7:0]  pl_addr = '0, h_addr = '0;
    logic        h_we = 1'b0;

    assign gnt_i    = req_o && (gcnt >= hold);
    assign rvalid_i = rv;
    assign rdata_i  = rd;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gcnt <= 0;
            rv   <= 1'b0;
        end else begin
            rv <= 1'b0;
            if (pl_en) mem[pl_addr[7:2]] <= pl_data;
            if (req_o) begin
                if (gcnt == 0) begin
                    h_addr  <= addr_o;
                    h_we    <= we_o;
                    h_wdata <= wdata_o;
                end else if (addr_o !== h_addr || we_o !== h_we || wdata_o !== h_wdata)
                    stab_err <= stab_err + 1;
                if (gnt_i) begin
                    gcnt <= 0;
                    rv   <= 1'b1;
                    log_addr[log_n[7:0]] <= addr_o;
                    log_we[log_n[7:0]]   <= we_o;
                    log_n <= log_n + 1;
                    if (we_o) mem[addr_o[7:2]] <= wdata_o;
                    else rd <= mem[addr_o[7:2]] ^ ((addr_o == bad_addr) ? 32'hFF : 32'h0);
                end else
                    gcnt <= gcnt + 1;
            end
        end
    end

    task automatic preload(input logic [7:0] a, input logic [31:0] d);
        @(negedge clk);
        pl_en = 1'b1; pl_addr = a; pl_data = d;
        @(negedge clk);
        pl_en = 1'b0;
    endtask

    task automatic run_copy(input logic [7:0] s, input logic [7:0] d, input logic [7:0] l,
                            input int mid_k, output int lat, output logic busy1, output int dones);
        lat = -1; dones = 0; busy1 = 1'b0;
        @(negedge clk);
        src_addr_i = s; dst_addr_i = d; len_i = l; start_i = 1'b1;
        for (int k = 1; k <= 600; k++) begin
            @(negedge clk);
            if (k == 1) begin start_i = 1'b0; busy1 = busy_o; end
            if (k == mid_k) begin start_i = 1'b1; src_addr_i = 8'h00; dst_addr_i = 8'h10; len_i = 8'd1; end
            if (k == mid_k + 1) start_i = 1'b0;
            if (done_o) begin dones++; if (lat < 0) lat = k; end
            if (lat > 0 && k >= lat + 3) break;
        end
    endtask

    task automatic check_log(input int base, input logic [7:0] s, input logic [7:0] d, input int l);
        logic [7:0] sa, da;
        check("traffic", log_n - base, TPW * l);
        for (int i = 0; i < l; i++) begin
            sa = s + 8'(4 * i);
            da = d + 8'(4 * i);
            check("rd_addr", {24'h0, log_addr[8'(base + TPW * i)]}, {24'h0, sa});
            check("rd_we", {31'h0, log_we[8'(base + TPW * i)]}, 32'h0);
            check("wr_addr", {24'h0, log_addr[8'(base + TPW * i + 1)]}, {24'h0, da});
            check("wr_we", {31'h0, log_we[8'(base + TPW * i + 1)]}, 32'h1);
`ifdef MEM_COPY_VERIFY_EN
            check("vf_addr", {24'h0, log_addr[8'(base + TPW * i + 2)]}, {24'h0, da});
            check("vf_we", {31'h0, log_we[8'(base + TPW * i + 2)]}, 32'h0);
`endif
        end
    endtask

    int   lat, dones, base;
    logic busy1;
    logic [31:0] fib [4] = '{32'h1, 32'h2, 32'h3, 32'h5};
    logic [31:0] wv  [4] = '{32'hA1, 32'hA2, 32'hA3, 32'hA4};

    initial begin
        #12;
        check("rst_req", {31'h0, req_o}, 32'h0);
        check("rst_we", {31'h0, we_o}, 32'h0);
        check("rst_addr", {24'h0, addr_o}, 32'h0);
        check("rst_wdata", wdata_o, 32'h0);
        check("rst_busy", {31'h0, busy_o}, 32'h0);
        check("rst_done", {31'h0, done_o}, 32'h0);
        check("rst_err", {31'h0, err_o}, 32'h0);
        check("rst_be", {28'h0, be_o}, 32'hF);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            preload(8'h80 + 8'(4 * i), fib[i]);
            preload(8'hF8 + 8'(4 * i), wv[i]);
        end
        preload(8'h10, 32'hDEAD0010);
        preload(8'hC0, 32'h0C0C0C0C);

        // Basic copy of four words
`ifdef MEM_COPY_VERIFY_EN
        bad_addr = 8'h94;
`endif
        base = log_n;
        run_copy(8'h80, 8'h90, 8'd4, 0, lat, busy1, dones);
        check("lat4", lat, 2 * TPW * 4 + 1);
        check("busy4", {31'h0, busy1}, 32'h1);
        check("done4", dones, 1);
        check_log(base, 8'h80, 8'h90, 4);
        for (int i = 0; i < 4; i++) check("mem90", mem[8'h24 + 6'(i)], fib[i]);
`ifdef MEM_COPY_VERIFY_EN
        check("err_set", {31'h0, err_o}, 32'h1);
        bad_addr = 8'hFF;
`else
        check("err_off", {31'h0, err_o}, 32'h0);
`endif

        base = log_n;
        run_copy(8'h80, 8'hA0, 8'd0, 0, lat, busy1, dones);
        check("lat0", lat, 1);
        check("busy0", {31'h0, busy1}, 32'h0);
        check("done0", dones, 1);
        check("traffic0", log_n - base, 0);
        check("err_clr", {31'h0, err_o}, 32'h0);

        hold = 3;
        base = log_n;
        run_copy(8'h80, 8'hA0, 8'd2, 0, lat, busy1, dones);
        check("lat_hold", lat, 5 * TPW * 2 + 1);
        check("stable", stab_err, 0);
        check_log(base, 8'h80, 8'hA0, 2);
        check("memA0", mem[6'h28], fib[0]);
        check("memA4", mem[6'h29], fib[1]);
        hold = 0;

        base = log_n;
        run_copy(8'h80, 8'hB0, 8'd4, 5, lat, busy1, dones);
        check("lat_mid", lat, 2 * TPW * 4 + 1);
        check("done_mid", dones, 1);
        check_log(base, 8'h80, 8'hB0, 4);
        for (int i = 0; i < 4; i++) check("memB0", mem[8'h2C + 6'(i)], fib[i]);
        check("mem10", mem[6'h04], 32'hDEAD0010);

        base = log_n;
        run_copy(8'hF8, 8'h40, 8'd4, 0, lat, busy1, dones);
        check("lat_wrap", lat, 2 * TPW * 4 + 1);
        check_log(base, 8'hF8, 8'h40, 4);
        for (int i = 0; i < 4; i++) check("mem40", mem[8'h10 + 6'(i)], wv[i]);

        // Abort while a write is pending
        hold = 3;
        @(negedge clk);
        src_addr_i = 8'h80; dst_addr_i = 8'hC0; len_i = 8'd2; start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        lat = -1;
        for (int k = 0; k < 100; k++) begin
            if (req_o && we_o) begin lat = k; break; end
            @(negedge clk);
        end
        check("wr_req_seen", {31'h0, req_o && we_o}, 32'h1);
        rst_n = 1'b0;
        #1;
        check("abort_req", {31'h0, req_o}, 32'h0);
        check("abort_busy", {31'h0, busy_o}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        hold = 0;
        dones = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (done_o) dones++;
            if (req_o || busy_o) dones += 100;
        end
        check("abort_idle", dones, 0);
        check("memC0", mem[6'h30], 32'h0C0C0C0C);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
